// File: rtl/adc_sample_averager.sv
// adc_sample_averager: truncated mean of 2^LOG2_N samples behind a one-deep valid/ready register; ADC_AVG_ALARM_EN adds a threshold alarm
module adc_sample_averager #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              overrun,
    input  logic              clear_overrun,
`ifdef ADC_AVG_ALARM_EN
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic              alarm,
`endif
    output logic [LOG2_N-1:0] sample_cnt
);
    localparam int ACC_W = DATA_W + LOG2_N;
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx, sum;
    logic [LOG2_N-1:0] cnt_nx;
    logic [DATA_W-1:0] mean;
    logic done, load;
    assign sum  = acc + ACC_W'(sample_in);
    assign mean = DATA_W'(sum >> LOG2_N);
    // a completed window is only accepted if the output slot is free or being popped
    assign load = done && (!avg_valid || avg_ready);
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = sample_cnt;
        done     = 1'b0;
        if (state == IDLE) begin
            acc_nx   = '0;
            cnt_nx   = '0;
            state_nx = enable ? ACCUM : IDLE;
        end else if (!enable) begin
            state_nx = IDLE;
            acc_nx   = '0;
            cnt_nx   = '0;
        end else if (sample_valid) begin
            done   = &sample_cnt;
            acc_nx = done ? '0 : sum;
            cnt_nx = sample_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            sample_cnt <= '0;
            avg_out    <= '0;
            avg_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            sample_cnt <= cnt_nx;
            avg_valid  <= load || (avg_valid && !avg_ready);
            overrun    <= (done && avg_valid && !avg_ready) || (overrun && !clear_overrun);
            if (load)
                avg_out <= mean;
        end
    end
`ifdef ADC_AVG_ALARM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            alarm <= 1'b0;
        else if (load)
            alarm <= (mean > thr_hi) || (mean < thr_lo);
    end
`endif
endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: directed and randomized checks against a window-queue reference model
module tb_adc_sample_averager;
    localparam int DATA_W = 12;
    localparam int LOG2_N = 3;
    localparam int N = 1 << LOG2_N;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, sample_valid = 1'b0;
    logic avg_ready = 1'b0, clear_overrun = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [DATA_W-1:0] avg_out;
    logic avg_valid, overrun;
    logic [LOG2_N-1:0] sample_cnt;
`ifdef ADC_AVG_ALARM_EN
    logic [DATA_W-1:0] thr_hi = 12'd3000, thr_lo = 12'd500;
    logic alarm;
    bit m_alarm;
`endif

    int total = 0, bad = 0;
    bit active;
    int win[$];
    logic [DATA_W-1:0] m_avg;
    bit m_valid, m_ovr;

    adc_sample_averager #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .avg_out(avg_out), .avg_valid(avg_valid),
        .avg_ready(avg_ready), .overrun(overrun), .clear_overrun(clear_overrun),
`ifdef ADC_AVG_ALARM_EN
        .thr_hi(thr_hi), .thr_lo(thr_lo), .alarm(alarm),
`endif
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        active = 0;
        win.delete();
        m_avg = '0;
        m_valid = 0;
        m_ovr = 0;
`ifdef ADC_AVG_ALARM_EN
        m_alarm = 0;
`endif
    endtask

    // one clock: drive inputs, advance the model by the same edge, sample 1 time unit later
    task automatic cyc(input bit en, input bit sv, input int si, input bit rdy, input bit clr);
        bit done = 0;
        int s = 0;
        logic [DATA_W-1:0] mean = '0;
        enable = en; sample_valid = sv; sample_in = DATA_W'(si);
        avg_ready = rdy; clear_overrun = clr;
        if (!active) active = en;
        else if (!en) begin
            active = 0;
            win.delete();
        end else if (sv) begin
            win.push_back(si);
            if (win.size() == N) begin
                foreach (win[i]) s += win[i];
                mean = DATA_W'(s / N);
                done = 1;
                win.delete();
            end
        end
        if (clr) m_ovr = 0;
        if (done && m_valid && !rdy) m_ovr = 1;
        else if (done) begin
            m_avg = mean;
            m_valid = 1;
`ifdef ADC_AVG_ALARM_EN
            m_alarm = (mean > thr_hi) || (mean < thr_lo);
`endif
        end else if (m_valid && rdy) m_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 4;
        if (avg_out !== 12'd0) begin bad++; $display("FAIL reset_avg_out got=%0d exp=0", avg_out); end
        if (avg_valid !== 1'b0) begin bad++; $display("FAIL reset_avg_valid got=%0b exp=0", avg_valid); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        if (sample_cnt !== 3'd0) begin bad++; $display("FAIL reset_sample_cnt got=%0d exp=0", sample_cnt); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < N; i++) cyc(1, 1, 100, 1, 0);
        total += 3;
        if (avg_out !== 12'd100) begin bad++; $display("FAIL basic_avg got=%0d exp=100", avg_out); end
        if (avg_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", avg_valid); end
        if (sample_cnt !== 3'd0) begin bad++; $display("FAIL basic_cnt got=%0d exp=0", sample_cnt); end
    endtask

    task automatic test_truncation();
        for (int i = 0; i < N; i++) cyc(1, 1, i, 1, 0);
        total++;
        if (avg_out !== 12'd3) begin bad++; $display("FAIL trunc_avg got=%0d exp=3", avg_out); end
        for (int i = 0; i < N; i++) cyc(1, 1, 4095, 1, 0);
        total += 2;
        if (avg_out !== 12'd4095) begin bad++; $display("FAIL full_scale_avg got=%0d exp=4095", avg_out); end
        if (avg_valid !== 1'b1) begin bad++; $display("FAIL full_scale_valid got=%0b exp=1", avg_valid); end
    endtask

    task automatic test_overrun();
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < N; i++) cyc(1, 1, 200, 0, 0);
        for (int i = 0; i < N; i++) cyc(1, 1, 50, 0, 0);
        total += 3;
        if (avg_out !== 12'd200) begin bad++; $display("FAIL ovr_avg got=%0d exp=200", avg_out); end
        if (avg_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%0b exp=1", avg_valid); end
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%0b exp=1", overrun); end
        cyc(1, 0, 0, 1, 0);
        total += 2;
        if (avg_valid !== 1'b0) begin bad++; $display("FAIL ovr_pop_valid got=%0b exp=0", avg_valid); end
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
        cyc(1, 0, 0, 0, 1);
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
    endtask

    task automatic test_disable();
        for (int i = 0; i < 5; i++) cyc(1, 1, 900, 1, 0);
        cyc(0, 1, 900, 1, 0);
        total++;
        if (sample_cnt !== 3'd0) begin bad++; $display("FAIL dis_cnt got=%0d exp=0", sample_cnt); end
        cyc(1, 1, 900, 1, 0);
        for (int i = 0; i < N; i++) cyc(1, 1, 10, 1, 0);
        total += 2;
        if (avg_out !== 12'd10) begin bad++; $display("FAIL dis_avg got=%0d exp=10", avg_out); end
        if (avg_valid !== 1'b1) begin bad++; $display("FAIL dis_valid got=%0b exp=1", avg_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < N; i++) cyc(1, 1, 77, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 33, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total += 3;
        if (avg_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%0b exp=0", avg_valid); end
        if (avg_out !== 12'd0) begin bad++; $display("FAIL async_avg got=%0d exp=0", avg_out); end
        if (sample_cnt !== 3'd0) begin bad++; $display("FAIL async_cnt got=%0d exp=0", sample_cnt); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef ADC_AVG_ALARM_EN
    task automatic test_alarm();
        thr_hi = 12'd3000;
        thr_lo = 12'd500;
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < N; i++) cyc(1, 1, 3100, 1, 0);
        total++;
        if (alarm !== 1'b1) begin bad++; $display("FAIL alarm_hi got=%0b exp=1", alarm); end
        for (int i = 0; i < N; i++) cyc(1, 1, 1000, 1, 0);
        total++;
        if (alarm !== 1'b0) begin bad++; $display("FAIL alarm_mid got=%0b exp=0", alarm); end
        for (int i = 0; i < N; i++) cyc(1, 1, 400, 1, 0);
        total++;
        if (alarm !== 1'b1) begin bad++; $display("FAIL alarm_lo got=%0b exp=1", alarm); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4095),
                $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            total += 4;
            if (avg_out !== m_avg) begin bad++; $display("FAIL rnd_avg c=%0d got=%0d exp=%0d", c, avg_out, m_avg); end
            if (avg_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, avg_valid, m_valid); end
            if (overrun !== m_ovr) begin bad++; $display("FAIL rnd_overrun c=%0d got=%0b exp=%0b", c, overrun, m_ovr); end
            if (sample_cnt !== LOG2_N'(win.size())) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, sample_cnt, win.size()); end
`ifdef ADC_AVG_ALARM_EN
            total++;
            if (alarm !== m_alarm) begin bad++; $display("FAIL rnd_alarm c=%0d got=%0b exp=%0b", c, alarm, m_alarm); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_overrun();
        test_disable();
        test_async_reset();
`ifdef ADC_AVG_ALARM_EN
        test_alarm();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
Downstream consumer of the SPI ADC controller's 12-bit conversion result. Accumulates a fixed window of 2^LOG2_N samples and emits the truncated mean through a valid/ready output register. The output register holds one result. Overrun is flagged when a new mean arrives while the previous one is still unconsumed. Sits between the ADC controller and the system data path (display/UART/processing).

Parameters:
DATA_W, 12, sample and result width in bits
LOG2_N, 3, log2 of window length; window N = 2^LOG2_N samples; legal range 1..8

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  averaging enabled; low discards the partial window
sample_in  input  DATA_W  conversion result from the ADC controller
sample_valid  input  1  one-cycle pulse; sample_in is valid this cycle
avg_out  output  DATA_W  mean of the last complete window
avg_valid  output  1  avg_out holds an unconsumed result
avg_ready  input  1  consumer accepts avg_out when avg_valid && avg_ready
overrun  output  1  sticky: a window result was dropped
clear_overrun  input  1  synchronous clear of overrun
sample_cnt  output  LOG2_N  samples accumulated in the current window

Behaviour:
- Reset is asynchronous, active-high, on clk. Reset values: acc=0, sample_cnt=0, avg_out=0, avg_valid=0, overrun=0, state=IDLE.
- Accumulator width is DATA_W+LOG2_N bits (15 by default), unsigned, and cannot overflow.
- FSM states: IDLE, ACCUM.
  - IDLE: acc=0, sample_cnt=0; sample_valid is ignored. Go to ACCUM on enable=1.
  - ACCUM: on sample_valid, acc += sample_in and sample_cnt += 1.
  - ACCUM, enable=0: go to IDLE next cycle. The partial window is discarded (acc and sample_cnt cleared). The output register is untouched.
- Window completion:
  - Condition: sample_valid while sample_cnt == N-1.
  - Mean = (acc + sample_in) >> LOG2_N, truncating, no rounding.
  - On the next clk edge: acc=0, sample_cnt=0 (wraps), state stays ACCUM.
  - avg_valid rises on the clk edge that registers the Nth sample; latency is 1 cycle from the Nth sample_valid.
- Output register rules:
  - Load when avg_valid=0, or when avg_valid && avg_ready in the same cycle (simultaneous pop+push: the new result is loaded and avg_valid stays 1).
  - Clear avg_valid when avg_valid && avg_ready and no completion this cycle.
  - Completion while avg_valid=1 && avg_ready=0: the new result is dropped, avg_out keeps the old value, overrun is set to 1.
- overrun is sticky until clear_overrun=1. If set and clear happen in the same cycle, set wins.
- avg_out is stable while avg_valid=1 && avg_ready=0.
- sample_valid in IDLE, or in the enable-deassert cycle, is not accumulated.
- Reset mid-window or mid-handshake returns all state to reset values immediately (asynchronous); no partial result is emitted.

Optional Feature:
- Macro: ADC_AVG_ALARM_EN.
- Defined:
  - Adds inputs thr_hi and thr_lo (each DATA_W) and output alarm (1 bit).
  - alarm is registered, updated only when a result is loaded into avg_out: 1 if mean > thr_hi or mean < thr_lo, else 0.
  - Dropped (overrun) results do not update alarm.
  - Reset value 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. reset, enable=1, 8 sample_valid pulses with sample_in=100, avg_ready=1 -> avg_out=100 and avg_valid=1 one cycle after the 8th pulse; sample_cnt back to 0.
2. Samples 0,1,...,7 (sum 28) -> avg_out=3 (truncation). Eight samples of 4095 -> avg_out=4095, no wrap.
3. avg_ready=0, two full windows (8x200 then 8x50) -> avg_out stays 200, overrun=1. Then avg_ready=1 for one cycle -> avg_valid=0. Then clear_overrun -> overrun=0.
4. 5 samples of 900, enable=0 for 1 cycle, enable=1, then 8 samples of 10 -> avg_out=10; sample_cnt was 0 after the disable.
5. Assert reset after 4 samples with avg_valid=1 pending -> avg_valid=0, avg_out=0, sample_cnt=0 immediately, without waiting for a clk edge.
6. (ADC_AVG_ALARM_EN) thr_hi=3000, thr_lo=500. Window of 8x3100 -> alarm=1; then 8x1000 -> alarm=0; then 8x400 -> alarm=1.
